// File: rtl/fp_op_dispatcher_pkg.sv
// Shared types for the FP operation dispatcher: FSM states, quiet-NaN constant
// and the queued request record.
package fp_disp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WB    = 3'd4
  } disp_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Widest tag the request record can carry; the dispatcher uses the low TAG_W bits.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [31:0]          op1;
    logic [31:0]          op2;
    logic [TAG_MAX_W-1:0] tag;
  } fp_req_t;

endpackage

// File: rtl/fp_op_dispatcher_if.sv
// Bundle of issue, FP-unit and writeback signals of the dispatcher.
// master = dispatcher side, slave = issue/FP-unit/writeback side.
interface fp_op_dispatcher_if #(
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_op1;
  logic [31:0]      req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             fu_arm;
  logic             fu_valid;
  logic [31:0]      fu_op1;
  logic [31:0]      fu_op2;
  logic             fu_done;
  logic [31:0]      fu_result;
  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_result;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_err;
  logic             busy;

  modport master (
    input  req_valid, req_op1, req_op2, req_tag, fu_done, fu_result, wb_ready,
    output req_ready, fu_arm, fu_valid, fu_op1, fu_op2,
           wb_valid, wb_result, wb_tag, wb_err, busy
  );

  modport slave (
    output req_valid, req_op1, req_op2, req_tag, fu_done, fu_result, wb_ready,
    input  req_ready, fu_arm, fu_valid, fu_op1, fu_op2,
           wb_valid, wb_result, wb_tag, wb_err, busy
  );

endinterface

// File: rtl/fp_op_dispatcher_fifo.sv
// Request queue for the dispatcher: synchronous FIFO with asynchronous reset,
// pointer-with-wrap-bit full/empty detection, head shown combinationally.
module fp_req_fifo
  import fp_disp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  fp_req_t i_data,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output fp_req_t o_head
);

  localparam int AW = $clog2(DEPTH);

  fp_req_t        r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/fp_op_dispatcher.sv
// Initiator-side sequencer for a multi-cycle FP unit: queue, arm/valid/done
// handshake, tagged writeback. Watchdog present when FP_DISP_TIMEOUT_EN is defined.
module fp_op_dispatcher
  import fp_disp_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fp_op_dispatcher_if.master  bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be >= 2");
  end
  if (TAG_W > TAG_MAX_W) begin : g_bad_tag
    $error("TAG_W exceeds TAG_MAX_W");
  end

  disp_state_t      r_state;
  disp_state_t      w_next_state;
  logic             w_pop;
  logic             w_capture;
  logic             w_timeout;
  logic             w_full;
  logic             w_empty;
  fp_req_t          w_req;
  fp_req_t          w_head;
  logic             w_unused_tag;
  logic             w_wdog_hit;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic [TAG_W-1:0] r_tag;
  logic             r_low_seen;
  logic [31:0]      r_wb_result;
  logic [TAG_W-1:0] r_wb_tag;
  logic             r_wb_err;

  assign w_req        = '{op1: bus.req_op1, op2: bus.req_op2, tag: TAG_MAX_W'(bus.req_tag)};
  assign w_unused_tag = ^w_head.tag;

  fp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (bus.req_valid),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef FP_DISP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] r_wdog_cnt;

  assign w_wdog_hit = (r_wdog_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wdog_cnt <= '0;
    end else if (w_pop) begin
      r_wdog_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
    end else begin
      r_wdog_cnt <= r_wdog_cnt;
    end
  end
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Done only counts once it has been seen low since the pop, so a level left
  // high by the previous operation cannot complete this one.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ARM;
        end else begin
          w_next_state = IDLE;
        end
      end
      ARM:   w_next_state = ISSUE;
      ISSUE: w_next_state = WAIT;
      WAIT: begin
        if (bus.fu_done && r_low_seen) begin
          w_capture    = 1'b1;
          w_next_state = WB;
        end else if (w_wdog_hit) begin
          w_timeout    = 1'b1;
          w_next_state = WB;
        end else begin
          w_next_state = WAIT;
        end
      end
      WB: begin
        if (bus.wb_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WB;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_tag       <= '0;
      r_low_seen  <= 1'b0;
      r_wb_result <= '0;
      r_wb_tag    <= '0;
      r_wb_err    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_op1      <= w_head.op1;
        r_op2      <= w_head.op2;
        r_tag      <= w_head.tag[TAG_W-1:0];
        r_low_seen <= 1'b0;
      end else if (r_state != IDLE && r_state != WB && !bus.fu_done) begin
        r_low_seen <= 1'b1;
      end
      if (w_capture) begin
        r_wb_result <= bus.fu_result;
        r_wb_tag    <= r_tag;
        r_wb_err    <= 1'b0;
      end else if (w_timeout) begin
        r_wb_result <= FP_QNAN;
        r_wb_tag    <= r_tag;
        r_wb_err    <= 1'b1;
      end
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.fu_arm    = (r_state == ARM);
  assign bus.fu_valid  = (r_state == ISSUE);
  assign bus.fu_op1    = r_op1;
  assign bus.fu_op2    = r_op2;
  assign bus.wb_valid  = (r_state == WB);
  assign bus.wb_result = r_wb_result;
  assign bus.wb_tag    = r_wb_tag;
`ifdef FP_DISP_TIMEOUT_EN
  assign bus.wb_err    = r_wb_err;
`else
  assign bus.wb_err    = 1'b0;
`endif
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fp_op_dispatcher.sv
// Scoreboard bench for fp_op_dispatcher with a behavioural FP-unit model that
// doubles operand A (op1 == op2 in every vector, so the result is A + B).
module tb_fp_op_dispatcher;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk;
  logic rst;

  fp_op_dispatcher_if #(.TAG_W(4)) bus ();

  fp_op_dispatcher #(.TAG_W(4), .DEPTH(2), .TIMEOUT(64)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // FP-unit model controls: 0 = drop done on arm, 1 = never done, 2 = keep stale done
  int          m_mode = 0;
  int          m_lat  = 10;
  int          m_drop = 6;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] op, input logic [3:0] tag, input exp_t e);
    int  n;
    logic ok;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_op1   = op;
    bus.req_op2   = op;
    bus.req_tag   = tag;
    do begin
      ok = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    bus.req_valid = 1'b0;
    if (!ok) begin
      chk("push_timeout", 32'(n), 32'd0);
    end else begin
      q.push_back(e);
    end
  endtask

  task automatic wait_wb_valid(input int bound, output int n);
    n = 0;
    while (!bus.wb_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.wb_valid) chk("wb_valid_timeout", 32'(bus.wb_valid), 32'd1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    cycles(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_fu_arm"},    32'(bus.fu_arm),    32'd0);
    chk({tag, "_fu_valid"},  32'(bus.fu_valid),  32'd0);
    chk({tag, "_wb_valid"},  32'(bus.wb_valid),  32'd0);
    chk({tag, "_wb_err"},    32'(bus.wb_err),    32'd0);
    chk({tag, "_fu_op1"},    bus.fu_op1,         32'd0);
    chk({tag, "_fu_op2"},    bus.fu_op2,         32'd0);
    chk({tag, "_wb_result"}, bus.wb_result,      32'd0);
    chk({tag, "_wb_tag"},    32'(bus.wb_tag),    32'd0);
  endtask

  // FP-unit model
  initial begin
    int          cyc;
    bit          active;
    logic [31:0] res_hold;
    cyc = 0;
    active = 1'b0;
    res_hold = 32'd0;
    bus.fu_done   = 1'b0;
    bus.fu_result = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.fu_done   = 1'b0;
        bus.fu_result = 32'd0;
        active        = 1'b0;
      end else begin
        if (bus.fu_arm && m_mode != 2) bus.fu_done = 1'b0;
        if (active) begin
          cyc++;
          if (m_mode == 2 && cyc == m_drop) bus.fu_done = 1'b0;
          if (m_mode != 1 && cyc == m_lat) begin
            bus.fu_done   = 1'b1;
            bus.fu_result = res_hold;
            active        = 1'b0;
          end
        end
        if (bus.fu_valid) begin
          active   = 1'b1;
          cyc      = 0;
          res_hold = bus.fu_op1 + 32'h0080_0000;
        end
      end
    end
  end

  // Monitor: pulse widths, held writeback stability, scoreboard compare
  initial begin
    logic        prev_arm, prev_valid, hold_v;
    logic [31:0] h_res;
    logic [3:0]  h_tag;
    logic        h_err;
    exp_t        e;
    prev_arm = 1'b0; prev_valid = 1'b0; hold_v = 1'b0;
    h_res = 32'd0; h_tag = 4'd0; h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_arm = 1'b0; prev_valid = 1'b0; hold_v = 1'b0;
      end else begin
        if (bus.fu_arm)   chk("arm_pulse_width",   32'(prev_arm),   32'd0);
        if (bus.fu_valid) chk("valid_pulse_width", 32'(prev_valid), 32'd0);
        prev_arm   = bus.fu_arm;
        prev_valid = bus.fu_valid;
        if (hold_v) begin
          chk("wb_hold_valid",  32'(bus.wb_valid), 32'd1);
          chk("wb_hold_result", bus.wb_result,     h_res);
          chk("wb_hold_tag",    32'(bus.wb_tag),   32'(h_tag));
          chk("wb_hold_err",    32'(bus.wb_err),   32'(h_err));
        end
        hold_v = bus.wb_valid && !bus.wb_ready;
        h_res  = bus.wb_result;
        h_tag  = bus.wb_tag;
        h_err  = bus.wb_err;
        if (bus.wb_valid && bus.wb_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb: got tag %h result %h expected no writeback",
                     bus.wb_tag, bus.wb_result);
          end else begin
            e = q.pop_front();
            chk("wb_result", bus.wb_result,   e.res);
            chk("wb_tag",    32'(bus.wb_tag), 32'(e.tag));
            chk("wb_err",    32'(bus.wb_err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op1   = 32'd0;
    bus.req_op2   = 32'd0;
    bus.req_tag   = 4'd0;
    bus.wb_ready  = 1'b1;
    cycles(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    cycles(2);
    check_reset_outputs("idle0");

    // 1.0 + 1.0, tag 3, done 10 cycles after valid
    m_mode = 0; m_lat = 10;
    push(32'h3F80_0000, 4'd3, '{32'h4000_0000, 4'd3, 1'b0});
    @(negedge clk);
    chk("t1_busy_before_pop", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("t1_arm",      32'(bus.fu_arm),   32'd1);
    chk("t1_arm_nv",   32'(bus.fu_valid), 32'd0);
    chk("t1_fu_op1",   bus.fu_op1, 32'h3F80_0000);
    chk("t1_fu_op2",   bus.fu_op2, 32'h3F80_0000);
    @(negedge clk);
    chk("t1_valid",    32'(bus.fu_valid), 32'd1);
    chk("t1_valid_na", 32'(bus.fu_arm),   32'd0);
    @(negedge clk);
    chk("t1_wait_nv",  32'(bus.fu_valid), 32'd0);
    chk("t1_wait_bsy", 32'(bus.busy),     32'd1);
    wait_wb_valid(100, n);
    chk("t1_done_latency", 32'(n), 32'd10);
    drain(50);

    // Writeback back-pressure: first result held, FIFO fills, drain in order
    m_lat = 3;
    bus.wb_ready = 1'b0;
    push(32'h3F80_0000, 4'd1, '{32'h4000_0000, 4'd1, 1'b0});
    wait_wb_valid(50, n);
    cycles(1);
    push(32'h4040_0000, 4'd2, '{32'h40C0_0000, 4'd2, 1'b0});
    push(32'h4120_0000, 4'd3, '{32'h41A0_0000, 4'd3, 1'b0});
    chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    cycles(4);
    chk("full_req_ready_later", 32'(bus.req_ready), 32'd0);
    chk("full_wb_valid",        32'(bus.wb_valid),  32'd1);
    bus.wb_ready = 1'b1;
    push(32'hC000_0000, 4'd4, '{32'hC080_0000, 4'd4, 1'b0});
    drain(200);

    // Stale done from the previous op must not complete the new one
    m_mode = 2; m_lat = 12; m_drop = 6;
    chk("stale_done_level", 32'(bus.fu_done), 32'd1);
    push(32'h4040_0000, 4'd7, '{32'h40C0_0000, 4'd7, 1'b0});
    drain(100);
    m_mode = 0;

    // Done on the watchdog's last cycle wins
    m_lat = 64;
    push(32'h4040_0000, 4'd5, '{32'h40C0_0000, 4'd5, 1'b0});
    drain(200);

    // Done one cycle too late
    m_lat = 65;
`ifdef FP_DISP_TIMEOUT_EN
    push(32'h4120_0000, 4'd6, '{QNAN, 4'd6, 1'b1});
`else
    push(32'h4120_0000, 4'd6, '{32'h41A0_0000, 4'd6, 1'b0});
`endif
    drain(200);

    // Unit never completes
    m_mode = 1;
`ifdef FP_DISP_TIMEOUT_EN
    push(32'h3F80_0000, 4'd9, '{QNAN, 4'd9, 1'b1});
    drain(300);
`else
    push(32'h3F80_0000, 4'd9, '{32'd0, 4'd9, 1'b0});
    q.delete();
    cycles(200);
    chk("never_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("never_busy",     32'(bus.busy),     32'd1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2);
`endif

    // Asynchronous reset mid-WAIT with one request queued
    push(32'h4040_0000, 4'd10, '{32'd0, 4'd0, 1'b0});
    push(32'h4120_0000, 4'd11, '{32'd0, 4'd0, 1'b0});
    q.delete();
    cycles(6);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_op1",  bus.fu_op1,    32'h4040_0000);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    cycles(2);
    rst = 1'b0;
    m_mode = 0;
    cycles(100);
    chk("post_rst_busy",     32'(bus.busy),     32'd0);
    chk("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
